// File: rtl/hall_pkg.sv
// Shared types and width helpers for the Hall-sensor slice tracker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hall_pkg;

    // Tracker lock state, also used to derive the locked/stalled outputs.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } tracker_state_t;

    // Width of the full-turn slice index (at least one bit).
    function automatic int slice_w(input int slices_per_turn);
        return (slices_per_turn > 1) ? $clog2(slices_per_turn) : 1;
    endfunction

    // log2 of the number of slices inside one sensor-to-sensor segment.
    function automatic int seg_w(input int slices_per_turn, input int num_sensors);
        return $clog2(slices_per_turn / num_sensors);
    endfunction

    // Width of a sensor index (at least one bit, even for a single sensor).
    function automatic int sens_w(input int num_sensors);
        return (num_sensors > 1) ? $clog2(num_sensors) : 1;
    endfunction

endpackage

// File: rtl/hall_input_filter.sv
// One Hall channel: 2-flop synchroniser, debounce, falling-edge trigger.
// Latency: raw edge to trig = 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; trig is a one-cycle pulse, re-armed only after the line reads inactive.
module hall_input_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hall_n,
    output logic trig
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync_q1;
    logic            sync_q2;
    logic            level_n;
    logic [DB_W-1:0] db_cnt;

    // Two-stage synchroniser; idles high (no magnet).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= hall_n;
            sync_q2 <= sync_q1;
        end
    end

    // Flip the filtered level after DEBOUNCE_CYCLES consecutive differing samples; pulse on going active.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_n <= 1'b1;
            db_cnt  <= '0;
            trig    <= 1'b0;
        end else begin
            trig <= 1'b0;
            if (sync_q2 != level_n) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_n <= sync_q2;
                    db_cnt  <= '0;
                    trig    <= ~sync_q2;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hall_slice_tracker.sv
// Measures Hall segment periods and emits per-slice sync pulses plus an offset full-turn slice index.
// Latency: trigger consumed -> position_sync/slice_cnt on the next cycle (both registered, aligned).
// Backpressure: none; free-running outputs, extra simultaneous triggers are dropped.
module hall_slice_tracker
    import hall_pkg::*;
#(
    parameter int NUM_SENSORS     = 2,
    parameter int SLICES_PER_TURN = 256,
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 2**24,
    localparam int SLICE_W        = slice_w(SLICES_PER_TURN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] hall_n,
    input  logic [SLICE_W-1:0]     slice_offset,
    output logic [SLICE_W-1:0]     slice_cnt,
    output logic                   position_sync,
    output logic                   locked,
    output logic                   stalled,
    output logic                   seq_error,
    output logic [CNT_W-1:0]       seg_period
);

    localparam int SEG_SLICES          = SLICES_PER_TURN / NUM_SENSORS;
    localparam int SEG_W               = seg_w(SLICES_PER_TURN, NUM_SENSORS);
    localparam int SENS_W              = sens_w(NUM_SENSORS);
    localparam logic [SLICE_W-1:0] SEG_LAST = SLICE_W'(SEG_SLICES - 1);

    tracker_state_t      state;
    tracker_state_t      state_nxt;
    logic [NUM_SENSORS-1:0] trig;
    logic                any_trig;
    logic [SENS_W-1:0]   trig_idx;
    logic [SENS_W-1:0]   last_idx;
    logic [SENS_W-1:0]   exp_idx;
    logic                seq_ok;
    logic                seq_err_nxt;
    logic [CNT_W-1:0]    period_cnt;
    logic                timeout;
    logic [CNT_W-1:0]    cps_raw;
    logic [CNT_W-1:0]    cps;
    logic [CNT_W-1:0]    slice_cyc;
    logic [CNT_W-1:0]    cyc_nxt;
    logic [SLICE_W-1:0]  raw;
    logic [SLICE_W-1:0]  raw_nxt;
    logic [SLICE_W-1:0]  seg_idx;
    logic                sync_nxt;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_filt
        hall_input_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filt (
            .clk    (clk),
            .rst    (rst),
            .hall_n (hall_n[g]),
            .trig   (trig[g])
        );
    end

    // Priority encoder: lowest-index trigger wins, the rest are dropped this cycle.
    always_comb begin
        any_trig = 1'b0;
        trig_idx = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (trig[i]) begin
                any_trig = 1'b1;
                trig_idx = SENS_W'(i);
            end
        end
    end

    // Saturating segment period counter, restarted at 1 by every trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (any_trig) begin
            period_cnt <= CNT_W'(1);
        end else if (period_cnt != '1) begin
            period_cnt <= period_cnt + CNT_W'(1);
        end
    end

    assign timeout = (period_cnt >= CNT_W'(TIMEOUT_CYCLES));

    // Latch the period only once a previous trigger bounds it (IDLE/STALLED periods are meaningless).
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_period <= '0;
        end else if (any_trig && (state == ACQUIRE || state == LOCKED)) begin
            seg_period <= period_cnt;
        end
    end

    // Cycles per slice, never zero so the slice stepper always advances.
    always_comb begin
        cps_raw = seg_period >> SEG_W;
        cps     = (cps_raw == '0) ? CNT_W'(1) : cps_raw;
    end

    // Remember which sensor fired last for the sequence check.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx <= '0;
        end else if (any_trig) begin
            last_idx <= trig_idx;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and sequence check; a trigger takes priority over the timeout so STALLED can recover.
    always_comb begin
        state_nxt   = state;
        seq_err_nxt = 1'b0;
        exp_idx     = (NUM_SENSORS == 1) ? '0 : (last_idx + SENS_W'(1));
        seq_ok      = (trig_idx == exp_idx);
        if (any_trig) begin
            case (state)
                IDLE:    state_nxt = ACQUIRE;
                ACQUIRE: begin
                    if (seq_ok) begin
                        state_nxt = LOCKED;
                    end else begin
                        seq_err_nxt = 1'b1;
                    end
                end
                LOCKED:  seq_err_nxt = ~seq_ok;
                STALLED: state_nxt = ACQUIRE;
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = STALLED;
        end
    end

    // Slice stepper: triggers resync to the sensor's segment base; the locking trigger already emits a sync.
    always_comb begin
        raw_nxt  = raw;
        cyc_nxt  = slice_cyc;
        sync_nxt = 1'b0;
        seg_idx  = raw & SEG_LAST;
        if (any_trig) begin
            raw_nxt  = SLICE_W'(trig_idx) << SEG_W;
            cyc_nxt  = '0;
            sync_nxt = (state_nxt == LOCKED);
        end else if (state == LOCKED) begin
            if (slice_cyc == cps - CNT_W'(1)) begin
                cyc_nxt = '0;
                // Hold on the last slice of the segment until the next sensor arrives.
                if (seg_idx != SEG_LAST) begin
                    raw_nxt  = raw + SLICE_W'(1);
                    sync_nxt = 1'b1;
                end
            end else begin
                cyc_nxt = slice_cyc + CNT_W'(1);
            end
        end
    end

    // Output registers: offset is applied to the next raw index so sync and index change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw           <= '0;
            slice_cyc     <= '0;
            slice_cnt     <= slice_offset;
            position_sync <= 1'b0;
            seq_error     <= 1'b0;
        end else begin
            raw           <= raw_nxt;
            slice_cyc     <= cyc_nxt;
            slice_cnt     <= raw_nxt + slice_offset;
            position_sync <= sync_nxt;
            seq_error     <= seq_err_nxt;
        end
    end

    assign locked  = (state == LOCKED);
    assign stalled = (state == IDLE) || (state == STALLED);

endmodule

// File: tb/tb_hall_slice_tracker.sv
// Self-checking bench for hall_slice_tracker (2 sensors, 256 slices, shortened timeout).
// Latency: n/a.
// Backpressure: n/a.
module tb_hall_slice_tracker;

    localparam int NS  = 2;
    localparam int SPT = 256;
    localparam int CW  = 32;
    localparam int DB  = 4;
    localparam int TO  = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] hall_n;
    logic [7:0]    slice_offset;
    logic [7:0]    slice_cnt;
    logic          position_sync;
    logic          locked;
    logic          stalled;
    logic          seq_error;
    logic [CW-1:0] seg_period;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int sync_total = 0;
    int seqerr_total = 0;
    int exp_q[$];
    int got_q[$];
    int got_t[$];
    int c_sync_cyc = 0;

    hall_slice_tracker #(
        .NUM_SENSORS(NS), .SLICES_PER_TURN(SPT), .CNT_W(CW),
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .hall_n(hall_n), .slice_offset(slice_offset),
        .slice_cnt(slice_cnt), .position_sync(position_sync), .locked(locked),
        .stalled(stalled), .seq_error(seq_error), .seg_period(seg_period)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    // One cycle: sample outputs on the falling edge and log sync events.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (position_sync) begin
            got_q.push_back(int'(slice_cnt));
            got_t.push_back(cyc);
            sync_total++;
        end
        if (seq_error) seqerr_total++;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse(input logic [NS-1:0] mask, input int low_len);
        hall_n = hall_n & ~mask;
        wait_cycles(low_len);
        hall_n = hall_n | mask;
    endtask

    // Sensor pulse followed by idle so consecutive calls start exactly 'period' cycles apart.
    task automatic segment(input logic [NS-1:0] mask, input int period);
        pulse(mask, 40);
        wait_cycles(period - 40);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hall_n = '1;
        wait_cycles(3);
        rst = 1'b0;
        clear_sb();
    endtask

    task automatic test_reset();
        int s0;
        rst = 1'b1;
        hall_n = '1;
        slice_offset = 8'd37;
        wait_cycles(3);
        n_cmp++;
        if (stalled !== 1'b1 || locked !== 1'b0 || position_sync !== 1'b0 || slice_cnt !== 8'd37 || seg_period !== '0) begin
            n_bad++;
            $display("FAIL reset_values: stalled=%0b locked=%0b sync=%0b slice=%0d period=%0d, required 1 0 0 37 0",
                     stalled, locked, position_sync, slice_cnt, seg_period);
        end
        rst = 1'b0;
        s0 = sync_total;
        wait_cycles(1000);
        n_cmp++;
        if (stalled !== 1'b1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_state: stalled=%0b locked=%0b, required stalled=1 locked=0", stalled, locked);
        end
        n_cmp++;
        if (sync_total - s0 !== 0) begin
            n_bad++;
            $display("FAIL idle_no_sync: %0d syncs seen, required 0", sync_total - s0);
        end
        n_cmp++;
        if (slice_cnt !== 8'd37) begin
            n_bad++;
            $display("FAIL idle_slice: slice_cnt=%0d, required 37", slice_cnt);
        end
        slice_offset = 8'd0;
    endtask

    task automatic test_glitch();
        do_reset();
        pulse(2'b01, 3);
        wait_cycles(20);
        n_cmp++;
        if (stalled !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_3cyc: stalled=%0b, required 1 (no trigger)", stalled);
        end
        pulse(2'b01, 4);
        wait_cycles(20);
        n_cmp++;
        if (stalled !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_4cyc: stalled=%0b locked=%0b, required stalled=0 locked=0", stalled, locked);
        end
    endtask

    task automatic test_lock();
        int e, g;
        do_reset();
        slice_offset = 8'd0;
        segment(2'b01, 12800);
        n_cmp++;
        if (locked !== 1'b0 || stalled !== 1'b0) begin
            n_bad++;
            $display("FAIL acquire_state: locked=%0b stalled=%0b, required locked=0 stalled=0", locked, stalled);
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL acquire_no_sync: %0d syncs, required 0", got_q.size());
        end
        clear_sb();
        for (int i = 0; i < 128; i++) exp_q.push_back(128 + i);
        segment(2'b10, 12800);
        n_cmp++;
        if (locked !== 1'b1 || seg_period !== 32'd12800) begin
            n_bad++;
            $display("FAIL lock_period: locked=%0b seg_period=%0d, required locked=1 seg_period=12800", locked, seg_period);
        end
        n_cmp++;
        if (got_t.size() < 2) begin
            n_bad++;
            $display("FAIL slice_spacing: %0d syncs, required at least 2", got_t.size());
        end else if (got_t[1] - got_t[0] !== 100) begin
            n_bad++;
            $display("FAIL slice_spacing: %0d cycles, required 100", got_t[1] - got_t[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++;
                $display("FAIL seg1_slice: no sync observed, required slice %0d", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL seg1_slice: got %0d, required %0d", g, e);
                end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL seg1_extra: %0d extra syncs, required 0", got_q.size());
        end
        clear_sb();
        for (int i = 0; i < 128; i++) exp_q.push_back(i);
        segment(2'b01, 12800);
        c_sync_cyc = (got_t.size() > 0) ? got_t[0] : cyc;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++;
                $display("FAIL seg0_slice: no sync observed, required slice %0d", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL seg0_slice: got %0d, required %0d", g, e);
                end
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL seg0_extra: %0d extra syncs, required 0", got_q.size());
        end
        clear_sb();
    endtask

    task automatic test_stall();
        int limit;
        n_cmp++;
        if (stalled !== 1'b0 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_stall: stalled=%0b locked=%0b, required stalled=0 locked=1", stalled, locked);
        end
        limit = c_sync_cyc + TO + 100;
        while (stalled !== 1'b1 && cyc < limit) cycle();
        n_cmp++;
        if (cyc !== c_sync_cyc + TO) begin
            n_bad++;
            $display("FAIL stall_time: stalled at +%0d cycles, required +%0d", cyc - c_sync_cyc, TO);
        end
        n_cmp++;
        if (slice_cnt !== 8'd127 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold: slice_cnt=%0d locked=%0b, required 127 and 0", slice_cnt, locked);
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_no_sync: %0d syncs, required 0", got_q.size());
        end
    endtask

    task automatic test_seq_error();
        int e, g, se0;
        do_reset();
        slice_offset = 8'd0;
        se0 = seqerr_total;
        segment(2'b01, 1280);
        segment(2'b10, 1280);
        segment(2'b01, 1280);
        n_cmp++;
        if (seqerr_total - se0 !== 0 || slice_cnt !== 8'd127) begin
            n_bad++;
            $display("FAIL seq_baseline: seq_errors=%0d slice_cnt=%0d, required 0 and 127", seqerr_total - se0, slice_cnt);
        end
        clear_sb();
        for (int i = 0; i < 128; i++) exp_q.push_back(i);
        segment(2'b01, 1280);
        n_cmp++;
        if (seqerr_total - se0 !== 1) begin
            n_bad++;
            $display("FAIL seq_pulse: %0d seq_error cycles, required 1", seqerr_total - se0);
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_locked: locked=%0b, required 1", locked);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++;
                $display("FAIL seq_resync: no sync observed, required slice %0d", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL seq_resync: got %0d, required %0d", g, e);
                end
            end
        end
        clear_sb();
    endtask

    task automatic test_offset_priority();
        int e, g, se0;
        se0 = seqerr_total;
        slice_offset = 8'd200;
        for (int i = 0; i < 128; i++) exp_q.push_back((128 + i + 200) % 256);
        segment(2'b10, 1280);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++;
                $display("FAIL offset_slice: no sync observed, required slice %0d", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL offset_slice: got %0d, required %0d", g, e);
                end
            end
        end
        clear_sb();
        for (int i = 0; i < 128; i++) exp_q.push_back((i + 200) % 256);
        segment(2'b11, 1280);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++;
                $display("FAIL prio_slice: no sync observed, required slice %0d", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL prio_slice: got %0d, required %0d", g, e);
                end
            end
        end
        n_cmp++;
        if (seqerr_total - se0 !== 0) begin
            n_bad++;
            $display("FAIL prio_seq: %0d seq_error cycles, required 0", seqerr_total - se0);
        end
        clear_sb();
    endtask

    task automatic test_reset_midop();
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_pre: locked=%0b, required 1", locked);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if (locked !== 1'b0 || stalled !== 1'b1 || seg_period !== '0 || slice_cnt !== 8'd200 || position_sync !== 1'b0) begin
            n_bad++;
            $display("FAIL midop_reset: locked=%0b stalled=%0b period=%0d slice=%0d sync=%0b, required 0 1 0 200 0",
                     locked, stalled, seg_period, slice_cnt, position_sync);
        end
        wait_cycles(50);
        n_cmp++;
        if (stalled !== 1'b1 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL midop_idle: stalled=%0b syncs=%0d, required 1 and 0", stalled, got_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        hall_n = '1;
        slice_offset = 8'd0;
        test_reset();
        test_glitch();
        test_lock();
        test_stall();
        test_seq_error();
        test_offset_priority();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
